// File: rtl/lb_window_ctrl.sv
// Line-buffer window controller for the convolution front end.
// Writes incoming pixel rows into NUM_LB buffers in rotation. Once KERNEL
// complete rows are held, it reads KERNEL adjacent buffers together so their
// outputs form a KERNEL x KERNEL window. After each pass it frees the top row.
module lb_window_ctrl #(
  parameter int COLS   = 6,
  parameter int NUM_LB = 4,
  parameter int KERNEL = 3,
  localparam int LBW   = $clog2(NUM_LB)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  input  logic              i_out_ready,
  output logic [NUM_LB-1:0] o_lb_wr_en,
  output logic [NUM_LB-1:0] o_lb_rd_en,
  output logic [LBW-1:0]    o_wr_sel,
  output logic [LBW-1:0]    o_rd_sel,
  output logic              o_window_valid,
  output logic              o_line_done,
  output logic [LBW:0]      o_lines_avail
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CW-1:0]  COL_ZERO     = '0;
  localparam logic [CW-1:0]  COL_ONE      = CW'(1);
  localparam logic [CW-1:0]  COL_LAST     = CW'(COLS - 1);
  localparam logic [CW-1:0]  COL_LAST_WIN = CW'(COLS - KERNEL);
  localparam logic [LBW-1:0] LB_ZERO      = '0;
  localparam logic [LBW-1:0] LB_ONE       = LBW'(1);
  localparam logic [LBW-1:0] LB_LAST      = LBW'(NUM_LB - 1);
  localparam logic [LBW:0]   AVAIL_ONE    = (LBW+1)'(1);
  localparam logic [LBW:0]   AVAIL_FULL   = (LBW+1)'(NUM_LB);
  localparam logic [LBW:0]   AVAIL_KERNEL = (LBW+1)'(KERNEL);

  logic [CW-1:0]  wr_col_reg, wr_col_next;
  logic [LBW-1:0] wr_lb_reg, wr_lb_next;
  logic [CW-1:0]  rd_col_reg, rd_col_next;
  logic [LBW-1:0] rd_lb_reg, rd_lb_next;
  logic [LBW:0]   lines_avail_reg, lines_avail_next;
  logic [1:0]     state_reg, state_next;

  logic pix_xfer;
  logic line_complete;
  logic read_beat;
  logic pass_end;
  logic rel_cycle;

  // True when buffer idx is one of the KERNEL rows starting at top (mod NUM_LB)
  function automatic logic in_window(input int idx, input logic [LBW-1:0] top);
    int off;
    off = idx - int'(top);
    if (off < 0) off = off + NUM_LB;
    return (off < KERNEL);
  endfunction

  // Ready is held low while reset is asserted so no enable escapes during reset
  assign o_pix_ready   = i_rst_n && (lines_avail_reg < AVAIL_FULL);
  assign pix_xfer      = i_pix_valid && o_pix_ready;
  assign line_complete = pix_xfer && (wr_col_reg == COL_LAST);
  assign read_beat     = (state_reg == ST_READ) && i_out_ready;
  assign pass_end      = read_beat && (rd_col_reg == COL_LAST);
  assign rel_cycle     = (state_reg == ST_RELEASE);

  assign o_wr_sel       = wr_lb_reg;
  assign o_rd_sel       = rd_lb_reg;
  assign o_window_valid = read_beat && (rd_col_reg <= COL_LAST_WIN);
  assign o_line_done    = rel_cycle;
  assign o_lines_avail  = lines_avail_reg;

  generate
    for (genvar gi = 0; gi < NUM_LB; gi++) begin : g_lb_en
      assign o_lb_wr_en[gi] = pix_xfer && (wr_lb_reg == LBW'(gi));
      assign o_lb_rd_en[gi] = read_beat && in_window(gi, rd_lb_reg);
    end
  endgenerate

  // Write pointer: advance column per pixel, move to next buffer at row end
  always_comb begin
    wr_col_next = wr_col_reg;
    wr_lb_next  = wr_lb_reg;
    if (pix_xfer) begin
      if (wr_col_reg == COL_LAST) begin
        wr_col_next = COL_ZERO;
        wr_lb_next  = (wr_lb_reg == LB_LAST) ? LB_ZERO : wr_lb_reg + LB_ONE;
      end else begin
        wr_col_next = wr_col_reg + COL_ONE;
      end
    end
  end

  // Read FSM: wait for KERNEL rows, stream COLS beats, then free the top row
  always_comb begin
    state_next  = state_reg;
    rd_col_next = rd_col_reg;
    rd_lb_next  = rd_lb_reg;
    case (state_reg)
      ST_IDLE: begin
        if (lines_avail_reg >= AVAIL_KERNEL) state_next = ST_READ;
      end
      ST_READ: begin
        if (pass_end) begin
          rd_col_next = COL_ZERO;
          state_next  = ST_RELEASE;
        end else if (read_beat) begin
          rd_col_next = rd_col_reg + COL_ONE;
        end
      end
      ST_RELEASE: begin
        rd_lb_next = (rd_lb_reg == LB_LAST) ? LB_ZERO : rd_lb_reg + LB_ONE;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Row occupancy: completed rows in, released rows out; both at once cancel
  always_comb begin
    lines_avail_next = lines_avail_reg;
    if (line_complete && !rel_cycle) begin
      lines_avail_next = lines_avail_reg + AVAIL_ONE;
    end else if (rel_cycle && !line_complete) begin
      lines_avail_next = lines_avail_reg - AVAIL_ONE;
    end
  end

  // State registers; reset discards partial rows and any pass in progress
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_col_reg      <= '0;
      wr_lb_reg       <= '0;
      rd_col_reg      <= '0;
      rd_lb_reg       <= '0;
      lines_avail_reg <= '0;
      state_reg       <= ST_IDLE;
    end else begin
      wr_col_reg      <= wr_col_next;
      wr_lb_reg       <= wr_lb_next;
      rd_col_reg      <= rd_col_next;
      rd_lb_reg       <= rd_lb_next;
      lines_avail_reg <= lines_avail_next;
      state_reg       <= state_next;
    end
  end

endmodule
